// File: rtl/key_debounce_pkg.sv
// Shared debounce constants for the key/switch input conditioning stage.
// Instantiating code and benches both take their defaults from here.
package key_debounce_pkg;

  localparam int KEY_WIDTH        = 8;
  localparam int KEY_TICK_DIV     = 50000;
  localparam int KEY_STABLE_TICKS = 20;

  typedef logic [KEY_WIDTH-1:0] key_vec_t;

endpackage

// File: rtl/key_debounce_bit.sv
// One key line: two-flop synchroniser, tick-driven stability counter and
// the debounced output bit; flip marks the cycle the output is about to change.
module debounce_bit
  import key_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = KEY_STABLE_TICKS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_raw,
  input  logic tick,
  output logic wd,
  output logic flip
);

  localparam int CW = $clog2(STABLE_TICKS) + 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Flip on the tick that completes STABLE_TICKS consecutive disagreeing ticks.
  assign flip = (sync2 != wd) && tick && (cnt == CW'(STABLE_TICKS - 1));

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage pipe.
    if (!Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      wd    <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      if (sync2 == wd) begin
        cnt <= '0;
      end else if (flip) begin
        wd  <= sync2;
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces WIDTH raw key lines onto the key peripheral's Wd input, with a
// shared sample-tick prescaler and a single Changed pulse per update.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int WIDTH        = KEY_WIDTH,
  parameter int TICK_DIV     = KEY_TICK_DIV,
  parameter int STABLE_TICKS = KEY_STABLE_TICKS
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Key_raw,
  output logic [WIDTH-1:0] Wd,
  output logic             Changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] flip;

  // With TICK_DIV=1 the count sits at 0 and tick is permanently high.
  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .Clk    (Clk),
      .Reset  (Reset),
      .key_raw(Key_raw[i]),
      .tick   (tick),
      .wd     (Wd[i]),
      .flip   (flip[i])
    );
  end

  // Bits flipping together share one pulse, aligned with the Wd update.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Changed <= 1'b0;
    end else begin
      Changed <= |flip;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Drives two debouncer configurations (TICK_DIV=1/STABLE=4 and TICK_DIV=4/STABLE=2)
// from shared stimulus and compares both against a run-length/tick-count model.
module tb_key_debounce;
  import key_debounce_pkg::*;

  localparam int TD_A = 1;
  localparam int ST_A = 4;
  localparam int TD_B = 4;
  localparam int ST_B = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key;
  logic [7:0] wd_a, wd_b;
  logic       chg_a, chg_b;

  int tests = 0;
  int fails = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  key_debounce #(.WIDTH(8), .TICK_DIV(TD_A), .STABLE_TICKS(ST_A)) dut_a (
    .Clk(clk), .Reset(rst), .Key_raw(key), .Wd(wd_a), .Changed(chg_a)
  );

  key_debounce #(.WIDTH(8), .TICK_DIV(TD_B), .STABLE_TICKS(ST_B)) dut_b (
    .Clk(clk), .Reset(rst), .Key_raw(key), .Wd(wd_b), .Changed(chg_b)
  );

  // Reference model: an output bit changes once the key line (seen two edges
  // late) has disagreed with it over an unbroken run spanning STABLE ticks.
  int         m_k;              // edges since reset release
  logic [7:0] hist[$];          // last two raw samples
  logic [7:0] m_wd[2];
  logic       m_chg[2];
  int         run_start[2][8];  // edge at which the current disagreement began

  function automatic int ticks_in(input int a, input int b, input int td);
    return (b + 1) / td - a / td;
  endfunction

  task automatic model_edge(input logic [7:0] raw, input logic rst_v);
    logic [7:0] s2;
    logic [7:0] nw;
    logic       flip;
    int         td, st;
    if (!rst_v) begin
      m_k = 0;
      hist.delete();
      for (int m = 0; m < 2; m++) begin
        m_wd[m]  = 8'h00;
        m_chg[m] = 1'b0;
        for (int i = 0; i < 8; i++) run_start[m][i] = -1;
      end
      return;
    end
    s2 = (hist.size() >= 2) ? hist[hist.size()-2] : 8'h00;
    for (int m = 0; m < 2; m++) begin
      td   = (m == 0) ? TD_A : TD_B;
      st   = (m == 0) ? ST_A : ST_B;
      nw   = m_wd[m];
      flip = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (s2[i] == m_wd[m][i]) begin
          run_start[m][i] = -1;
        end else begin
          if (run_start[m][i] < 0) run_start[m][i] = m_k;
          if (ticks_in(run_start[m][i], m_k, td) == st) begin
            nw[i] = s2[i];
            run_start[m][i] = -1;
            flip = 1'b1;
          end
        end
      end
      m_wd[m]  = nw;
      m_chg[m] = flip;
    end
    hist.push_back(raw);
    if (hist.size() > 2) void'(hist.pop_front());
    m_k++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] raw_s;
    logic       rst_s;
    raw_s = key;
    rst_s = rst;
    @(posedge clk);
    model_edge(raw_s, rst_s);
    #1;
    check("model_wd_a", wd_a, m_wd[0]);
    check("model_chg_a", 8'(chg_a), 8'(m_chg[0]));
    check("model_wd_b", wd_b, m_wd[1]);
    check("model_chg_b", 8'(chg_b), 8'(m_chg[1]));
    if (chg_a) pulses_a++;
    if (chg_b) pulses_b++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Wait until a key change applied now makes the B disagreement start at a tick-phase 0.
  task automatic align_b();
    while (((m_k + 2) % TD_B) != 0) step();
  endtask

  initial begin
    int dur;
    int cyc;

    // Reset held with all keys high, then release: full filtering applies.
    key = 8'hFF;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("rst_wd_a", wd_a, 8'h00);
      check("rst_chg_a", 8'(chg_a), 8'h00);
      check("rst_wd_b", wd_b, 8'h00);
    end
    rst = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      if (n == 4) check("rel_wd_a_early", wd_a, 8'h00);
      if (n == 5) begin
        check("rel_wd_a", wd_a, 8'hFF);
        check("rel_chg_a", 8'(chg_a), 8'h01);
      end
      if (n == 6) check("rel_chg_a_low", 8'(chg_a), 8'h00);
      if (n == 7) check("rel_wd_b", wd_b, 8'hFF);
    end

    // Clean press on bit 0.
    key = 8'h00;
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle(4);
    key = 8'h01;
    pulses_a = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (n == 4) check("press_wd_early", wd_a, 8'h00);
      if (n == 5) begin
        check("press_wd", wd_a, 8'h01);
        check("press_chg", 8'(chg_a), 8'h01);
      end
      if (n == 6) check("press_chg_low", 8'(chg_a), 8'h00);
    end
    idle(12);
    key = 8'h00;
    idle(16);

    // Bounce reject on bit 3: two-cycle pulses, never stable long enough.
    pulses_a = 0;
    pulses_b = 0;
    for (int p = 0; p < 4; p++) begin
      key = (p % 2 == 0) ? 8'h08 : 8'h00;
      idle(2);
    end
    idle(12);
    check("bounce_wd_a", wd_a, 8'h00);
    check("bounce_pulses_a", 8'(pulses_a), 8'h00);
    check("bounce_pulses_b", 8'(pulses_b), 8'h00);

    // Bounce then settle on bit 5.
    pulses_a = 0;
    for (int g = 0; g < 3; g++) begin
      key = 8'h20;
      step();
      key = 8'h00;
      step();
    end
    key = 8'h20;
    for (int n = 0; n < 6; n++) begin
      step();
      if (n == 4) check("settle_wd_early", wd_a, 8'h00);
      if (n == 5) check("settle_wd", wd_a, 8'h20);
    end
    idle(15);
    check("settle_pulses", 8'(pulses_a), 8'h01);
    key = 8'h00;
    idle(16);

    // Simultaneous rise of bits 1 and 6, then release of bit 1 only.
    pulses_a = 0;
    pulses_b = 0;
    key = 8'h42;
    for (int n = 0; n < 6; n++) begin
      step();
      if (n == 5) begin
        check("simul_wd", wd_a, 8'h42);
        check("simul_chg", 8'(chg_a), 8'h01);
      end
    end
    idle(15);
    check("simul_pulses_a", 8'(pulses_a), 8'h01);
    check("simul_pulses_b", 8'(pulses_b), 8'h01);
    pulses_a = 0;
    key = 8'h40;
    idle(15);
    check("release1_wd_a", wd_a, 8'h40);
    check("release1_wd_b", wd_b, 8'h40);
    check("release1_pulses", 8'(pulses_a), 8'h01);
    key = 8'h00;
    idle(20);

    // Prescaler: 5-cycle glitch on bit 2 spans a single tick of B.
    align_b();
    pulses_b = 0;
    key = 8'h04;
    idle(5);
    key = 8'h00;
    idle(12);
    check("presc_glitch_pulses_b", 8'(pulses_b), 8'h00);
    check("presc_glitch_wd_b", wd_b, 8'h00);

    // Held change on bit 2: flips on the second tick after sync2 differs.
    align_b();
    key = 8'h04;
    for (int n = 0; n < 11; n++) begin
      step();
      if (n == 8) check("presc_hold_early", wd_b, 8'h00);
      if (n == 9) begin
        check("presc_hold_wd", wd_b, 8'h04);
        check("presc_hold_chg", 8'(chg_b), 8'h01);
      end
    end

    // Reset in the middle of the release count.
    key = 8'h00;
    idle(4);
    rst = 1'b0;
    step();
    check("midrst_wd_b", wd_b, 8'h00);
    check("midrst_chg_b", 8'(chg_b), 8'h00);
    check("midrst_wd_a", wd_a, 8'h00);
    rst = 1'b1;
    idle(12);
    check("midrst_after_wd_b", wd_b, 8'h00);

    // Randomised bursts of bouncing keys with occasional resets.
    cyc = 0;
    while (cyc < 1500) begin
      key = key ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
        cyc++;
      end
      dur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 5));
      idle(dur);
      cyc += dur;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
